cpu8_led_core: RTL and testbench

// 8-bit single-cycle CPU core fetching 16-bit words from the external single-port BSRAM.

---
 rtl/cpu8_led_core_pkg.sv | 38 +++
 rtl/cpu8_led_core_if.sv | 8 +
 rtl/cpu8_led_core_alu.sv | 50 +++++
 rtl/cpu8_led_core.sv | 82 ++++++++
 tb/tb_cpu8_led_core.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu8_led_core_pkg.sv
// Shared types, opcode set and instruction decoder for the 8-bit LED-matrix CPU.
package cpu8_pkg;

    localparam int ADR_W = 11;

    typedef logic [2:0] reg_idx_t;
    typedef logic [7:0] word_t;

    typedef enum logic [3:0] {
        OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_INC, OP_DEC, OP_NOT, OP_ROT,
        OP_JNC, OP_JMP, OP_MVI, OP_MVIH,
        OP_IN,  OP_NOP
    } op_t;

    function automatic op_t decode_op(input word_t i_ins);
        op_t w_op;
        casez (i_ins)
            8'b00??????: w_op = OP_MOV;
            8'b01000???: w_op = OP_ADD;
            8'b01001???: w_op = OP_SUB;
            8'b01010???: w_op = OP_AND;
            8'b01011???: w_op = OP_OR;
            8'b01100???: w_op = OP_INC;
            8'b01101???: w_op = OP_DEC;
            8'b01110???: w_op = OP_NOT;
            8'b01111???: w_op = OP_ROT;
            8'b1000????: w_op = OP_JNC;
            8'b1001????: w_op = OP_JMP;
            8'b1010????: w_op = OP_MVI;
            8'b1011????: w_op = OP_MVIH;
            8'b11000???: w_op = OP_IN;
            default:     w_op = OP_NOP;
        endcase
        return w_op;
    endfunction

endpackage

// File: rtl/cpu8_led_core_if.sv
// Instruction fetch bus between the core (master) and the external BSRAM (slave).
interface cpu8_led_core_if #(parameter int ADR_W = 11);
    logic [ADR_W-1:0] adr;
    logic [15:0]      dout;

    modport master (output adr, input  dout);
    modport slave  (input  adr, output dout);
endinterface

// File: rtl/cpu8_led_core_alu.sv
// Combinational ALU; carry_in passes through unchanged for ops that do not touch carry.
module cpu8_alu
    import cpu8_pkg::*;
(
    input  op_t   i_op,
    input  word_t i_a,
    input  word_t i_b,
    input  logic  i_carry,
    output word_t o_result,
    output logic  o_carry
);

    logic [8:0] w_wide;

    always_comb begin
        w_wide   = 9'd0;
        o_result = i_a;
        o_carry  = i_carry;
        unique case (i_op)
            OP_MOV: o_result = i_b;
            OP_ADD: begin
                w_wide   = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_wide[7:0];
                o_carry  = w_wide[8];
            end
            // bit 8 of a 9-bit difference is the borrow
            OP_SUB: begin
                w_wide   = {1'b0, i_a} - {1'b0, i_b};
                o_result = w_wide[7:0];
                o_carry  = w_wide[8];
            end
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_INC: begin
                w_wide   = {1'b0, i_a} + 9'd1;
                o_result = w_wide[7:0];
                o_carry  = w_wide[8];
            end
            OP_DEC: begin
                w_wide   = {1'b0, i_a} - 9'd1;
                o_result = w_wide[7:0];
                o_carry  = w_wide[8];
            end
            OP_NOT: o_result = ~i_a;
            OP_ROT: o_result = {i_a[6:0], i_a[7]};
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu8_led_core.sv
// Single-cycle 8-bit CPU: one instruction per clk edge, register file scanned onto an 8x8 LED matrix.
module cpu8_led_core #(
    parameter int ADR_W    = cpu8_pkg::ADR_W,
    parameter int NREG     = 8,
    parameter int SCAN_LSB = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  btn,
    input  logic [23:0] counter,
    cpu8_led_core_if.master mem,
    output logic [3:0]  led,
    output logic [7:0]  col,
    output logic [7:0]  row
);

    import cpu8_pkg::*;

    logic [ADR_W-1:0] r_pc;
    word_t            r_regs [NREG];
    logic             r_carry;

    word_t    w_ins;
    op_t      w_op;
    reg_idx_t w_src;
    reg_idx_t w_dst;
    logic [3:0] w_imm;
    word_t    w_alu_a;
    word_t    w_alu_res;
    logic     w_alu_carry;
    logic [2:0] w_k;
    logic     w_unused_bits;

    assign w_ins  = mem.dout[7:0];
    assign w_op   = decode_op(w_ins);
    assign w_src  = w_ins[2:0];
    assign w_dst  = w_ins[5:3];
    assign w_imm  = w_ins[3:0];
    assign w_unused_bits = ^{mem.dout[15:8], counter};

    // single-register ops work on rrr; two-operand ops always accumulate into r0
    assign w_alu_a = (w_op inside {OP_INC, OP_DEC, OP_NOT, OP_ROT}) ? r_regs[w_src] : r_regs[0];

    cpu8_alu u_alu (
        .i_op     (w_op),
        .i_a      (w_alu_a),
        .i_b      (r_regs[w_src]),
        .i_carry  (r_carry),
        .o_result (w_alu_res),
        .o_carry  (w_alu_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_carry <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            r_pc    <= r_pc + ADR_W'(1);
            r_carry <= w_alu_carry;
            unique case (w_op)
                OP_MOV:                         r_regs[w_dst] <= w_alu_res;
                OP_ADD, OP_SUB, OP_AND, OP_OR:  r_regs[0]     <= w_alu_res;
                OP_INC, OP_DEC, OP_NOT, OP_ROT: r_regs[w_src] <= w_alu_res;
                OP_JNC: if (!r_carry) r_pc <= ADR_W'(w_imm);
                OP_JMP:  r_pc           <= ADR_W'(w_imm);
                OP_MVI:  r_regs[0]      <= {4'b0000, w_imm};
                OP_MVIH: r_regs[0][7:4] <= w_imm;
                OP_IN:   r_regs[w_src]  <= btn;
                default: ;
            endcase
        end
    end

    assign mem.adr = r_pc;
    assign led     = r_pc[3:0];

    assign w_k = counter[SCAN_LSB+2:SCAN_LSB];
    assign row = 8'b0000_0001 << w_k;
    assign col = ~r_regs[w_k];

endmodule

// File: tb/tb_cpu8_led_core.sv
// Directed and randomized bench for cpu8_led_core against an instruction-level reference model.
`timescale 1ns/1ps
module tb_cpu8_led_core;

    localparam int SCAN_LSB = 13;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  btn = 8'h00;
    logic [23:0] counter = 24'h0;
    logic [3:0]  led;
    logic [7:0]  col;
    logic [7:0]  row;

    logic [15:0] mem [2048];
    logic [7:0]  prog [$];

    cpu8_led_core_if bus ();
    assign bus.dout = mem[bus.adr];

    cpu8_led_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .counter (counter),
        .mem     (bus),
        .led     (led),
        .col     (col),
        .row     (row)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int m_pc;
    int m_c;
    int m_r [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_c  = 0;
        for (int i = 0; i < 8; i++) m_r[i] = 0;
    endtask

    // Instruction semantics with plain integer arithmetic
    task automatic model_exec(input logic [7:0] ins);
        int d, s, imm, t, nxt;
        d   = int'(ins[5:3]);
        s   = int'(ins[2:0]);
        imm = int'(ins[3:0]);
        nxt = (m_pc + 1) % 2048;
        if (ins[7:6] == 2'b00) begin
            t = m_r[s];
            m_r[d] = t;
        end else if (ins[7:6] == 2'b01) begin
            case (int'(ins[5:3]))
                0: begin t = m_r[0] + m_r[s]; m_c = (t > 255) ? 1 : 0; m_r[0] = t % 256; end
                1: begin m_c = (m_r[0] < m_r[s]) ? 1 : 0; m_r[0] = (m_r[0] - m_r[s] + 256) % 256; end
                2: m_r[0] = m_r[0] & m_r[s];
                3: m_r[0] = m_r[0] | m_r[s];
                4: begin m_c = (m_r[s] == 255) ? 1 : 0; m_r[s] = (m_r[s] + 1) % 256; end
                5: begin m_c = (m_r[s] == 0) ? 1 : 0; m_r[s] = (m_r[s] + 255) % 256; end
                6: m_r[s] = 255 - m_r[s];
                default: m_r[s] = (m_r[s] * 2 + m_r[s] / 128) % 256;
            endcase
        end else if (ins[7:6] == 2'b10) begin
            case (int'(ins[5:4]))
                0: if (m_c == 0) nxt = imm;
                1: nxt = imm;
                2: m_r[0] = imm;
                default: m_r[0] = imm * 16 + (m_r[0] % 16);
            endcase
        end else if (ins[5:3] == 3'b000) begin
            m_r[s] = int'(btn);
        end
        m_pc = nxt;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_adr"}, 32'(bus.adr), 32'(m_pc));
        check({tag, "_led"}, 32'(led), 32'(m_pc % 16));
        for (int k = 0; k < 8; k++) begin
            counter = {8'($urandom), 3'(k), 13'($urandom)};
            #1;
            check($sformatf("%s_row%0d", tag, k), 32'(row), 32'(1 << k));
            check($sformatf("%s_col%0d", tag, k), 32'(col), 32'(255 - m_r[k]));
        end
    endtask

    task automatic read_reg(input int k, output logic [7:0] v);
        counter = 24'(k) << SCAN_LSB;
        #1;
        v = ~col;
    endtask

    task automatic step_n(input int n, input string tag);
        logic [7:0] ins;
        for (int i = 0; i < n; i++) begin
            ins = mem[m_pc][7:0];
            @(posedge clk);
            model_exec(ins);
            @(negedge clk);
            check_state(tag);
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 2048; i++) mem[i] = {8'($urandom), 8'hC8};
        for (int i = 0; i < prog.size(); i++) mem[i] = {8'($urandom), prog[i]};
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_state(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] v;

    initial begin
        model_reset();
        for (int i = 0; i < 2048; i++) mem[i] = 16'h00C8;

        // Reset state
        #5;
        check_state("reset0");

        // Rotating counter program
        prog = '{8'hA1, 8'h78, 8'h66, 8'h08, 8'h61, 8'h11, 8'h62,
                 8'h1A, 8'h63, 8'h23, 8'h64, 8'h91};
        load_prog();
        do_reset("reset1");
        step_n(12, "prog");
        read_reg(0, v); check("prog12_r0", 32'(v), 32'h2);
        read_reg(1, v); check("prog12_r1", 32'(v), 32'h3);
        read_reg(4, v); check("prog12_r4", 32'(v), 32'h6);
        read_reg(6, v); check("prog12_r6", 32'(v), 32'h1);
        check("prog12_adr", 32'(bus.adr), 32'd1);
        step_n(11, "prog");
        read_reg(0, v); check("prog23_r0", 32'(v), 32'h4);
        read_reg(4, v); check("prog23_r4", 32'(v), 32'h8);
        read_reg(6, v); check("prog23_r6", 32'(v), 32'h2);

        // Carry and JNC
        prog = '{8'hAF, 8'hBF, 8'h60, 8'h85, 8'h68, 8'hA1, 8'h40, 8'h85};
        load_prog();
        do_reset("reset2");
        step_n(3, "carry");
        read_reg(0, v); check("inc_wrap_r0", 32'(v), 32'h0);
        step_n(1, "carry");
        check("jnc_fall_adr", 32'(bus.adr), 32'd4);
        step_n(1, "carry");
        read_reg(0, v); check("dec_wrap_r0", 32'(v), 32'hFF);
        step_n(2, "carry");
        read_reg(0, v); check("add_r0", 32'(v), 32'h2);
        step_n(1, "carry");
        check("jnc_taken_adr", 32'(bus.adr), 32'd5);

        // IN instruction and matrix scan of r3
        prog = '{8'hC3};
        load_prog();
        do_reset("reset3");
        btn = 8'h01;
        step_n(1, "in");
        counter = 24'(3) << SCAN_LSB;
        #1;
        check("in_row3", 32'(row), 32'h08);
        check("in_col3", 32'(col), 32'hFE);

        // Randomized program and buttons
        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
        do_reset("reset4");
        for (int i = 0; i < 600; i++) begin
            btn = 8'($urandom);
            step_n(1, "rand");
        end

        // PC wrap through a full NOP field
        prog = '{};
        load_prog();
        do_reset("reset5");
        step_n(2047, "wrap");
        check("wrap_2047", 32'(bus.adr), 32'd2047);
        step_n(1, "wrap");
        check("wrap_0", 32'(bus.adr), 32'd0);
        step_n(3, "wrap");

        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_adr", 32'(bus.adr), 32'd0);
        check_state("async");
        @(negedge clk);
        rst_n = 1'b1;
        step_n(2, "post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
